// File: rtl/seg_scan_if.sv
// Display-side bundle for the 8-digit 7-segment scanner.
// master drives value/enable, slave (the scanner) drives digit outputs.
interface seg_scan_if;
  logic        en;
  logic [31:0] data;
  logic [31:0] ext;
  logic [7:0]  an;
  logic [3:0]  hex;
  logic [3:0]  extend;
  logic        flash;
  logic        frame_done;

  modport master (
    output en, data, ext,
    input  an, hex, extend, flash, frame_done
  );

  modport slave (
    input  en, data, ext,
    output an, hex, extend, flash, frame_done
  );
endinterface

// File: rtl/seg_scan.sv
// Time-multiplexed common-anode 7-segment scanner with
// per-frame snapshot, inter-digit blanking and blink phase.
module seg_scan #(
  parameter int BLANK_CYC = 16,
  parameter int ON_CYC    = 50000,
  parameter int FLASH_CYC = 25000000
) (
  input logic       clk,
  input logic       rst,
  seg_scan_if.slave bus
);

  localparam int MAX_BO = (BLANK_CYC > ON_CYC) ? BLANK_CYC : ON_CYC;
  localparam int MAXP   = (MAX_BO > FLASH_CYC) ? MAX_BO : FLASH_CYC;
  localparam int CW     = $clog2(MAXP + 1);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] FLASH_LAST = CW'(FLASH_CYC - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] ON    = 2'd2;

  localparam logic [3:0] EXT_OFF = 4'b0111;

  logic [1:0]    state;
  logic [2:0]    idx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] fcnt;
  logic [31:0]   sh_data;
  logic [31:0]   sh_ext;

  logic [7:0]    an_q;
  logic [3:0]    hex_q;
  logic [3:0]    ext_q;
  logic          flash_q;
  logic          fd_q;

  logic [31:0]   cur_data;
  logic [31:0]   cur_ext;
  logic [4:0]    sel;
  logic [3:0]    nib;
  logic [3:0]    xnib;

  // Digit 0 shows the value captured on the very edge it lights up.
  assign cur_data = (idx == 3'd0) ? bus.data : sh_data;
  assign cur_ext  = (idx == 3'd0) ? bus.ext  : sh_ext;
  assign sel      = {idx, 2'b00};
  assign nib      = cur_data[sel +: 4];
  assign xnib     = cur_ext[sel +: 4];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= 3'd0;
      cnt     <= '0;
      sh_data <= '0;
      sh_ext  <= '0;
      an_q    <= 8'hFF;
      hex_q   <= 4'h0;
      ext_q   <= EXT_OFF;
      fd_q    <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      case (state)
        IDLE: begin
          an_q  <= 8'hFF;
          ext_q <= EXT_OFF;
          if (bus.en) begin
            state <= BLANK;
            idx   <= 3'd0;
            cnt   <= '0;
          end
        end
        BLANK: begin
          if (!bus.en) begin
            state <= IDLE;
            idx   <= 3'd0;
            cnt   <= '0;
            an_q  <= 8'hFF;
            ext_q <= EXT_OFF;
          end else if (cnt == BLANK_LAST) begin
            state <= ON;
            cnt   <= '0;
            if (idx == 3'd0) begin
              sh_data <= bus.data;
              sh_ext  <= bus.ext;
            end
            an_q  <= ~(8'd1 << idx);
            hex_q <= nib;
            ext_q <= xnib;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ON: begin
          if (!bus.en) begin
            state <= IDLE;
            idx   <= 3'd0;
            cnt   <= '0;
            an_q  <= 8'hFF;
            ext_q <= EXT_OFF;
          end else if (cnt == ON_LAST) begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= idx + 3'd1;
            an_q  <= 8'hFF;
            ext_q <= EXT_OFF;
            fd_q  <= (idx == 3'd7);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          idx   <= 3'd0;
          cnt   <= '0;
          an_q  <= 8'hFF;
          ext_q <= EXT_OFF;
        end
      endcase
    end
  end

  // Blink phase runs regardless of scan state.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt    <= '0;
      flash_q <= 1'b0;
    end else if (fcnt == FLASH_LAST) begin
      fcnt    <= '0;
      flash_q <= ~flash_q;
    end else begin
      fcnt <= fcnt + CW'(1);
    end
  end

  assign bus.an         = an_q;
  assign bus.hex        = hex_q;
  assign bus.extend     = ext_q;
  assign bus.flash      = flash_q;
  assign bus.frame_done = fd_q;

endmodule
